// File: rtl/drive_phase_sequencer.sv
// drive_phase_sequencer: per-phase field store plus PWM phase driver.
// Holds DRIVE/SENSE/DELAY/TWEAKi fields for the P (high) and N (low) phases,
// tracks time since the last PWM edge with a saturating one-hot step counter,
// and forces both drivers off for DEAD_CYCLES cycles after every PWM edge.
// Build option: define TWEAK_GATE_EN to zero each tweak lane whose selected
// phase SENSE bit does not match the applied phase.
// Field map (B = 0 for P, PF for N): B+0 DRIVE, B+1 SENSE, B+2 DELAY, B+3+i TWEAKi.
module drive_phase_sequencer #(
  parameter int WIDTH       = 8,
  parameter int NTWEAK      = 8,
  parameter int NSTEPS      = 8,
  parameter int DEAD_CYCLES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pwm,
  input  logic [ADDR_W-1:0]        field_addr,
  input  logic [WIDTH-1:0]         field_wdata,
  input  logic                     field_we,
  output logic [WIDTH-1:0]         field_rdata,
  output logic [NSTEPS-1:0]        step_sel,
  output logic                     phase,
  output logic                     dead,
  output logic [WIDTH-1:0]         p_drive,
  output logic [WIDTH-1:0]         n_drive,
  output logic [WIDTH-1:0]         tweak_delay,
  output logic [WIDTH-1:0]         tweak_sense,
  output logic [NTWEAK*WIDTH-1:0]  tweak_drive
);

  localparam int PF    = 3 + NTWEAK;
  localparam int DEPTH = 2 * PF;
  localparam int DCW   = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]        field_q [DEPTH];
  logic                    pwm_prev_q;
  logic [NSTEPS-1:0]       step_q, step_d;
  logic [DCW-1:0]          dead_cnt_q, dead_cnt_d;
  logic [WIDTH-1:0]        rdata_q, rdata_d;
  logic                    phase_q, dead_q;
  logic [WIDTH-1:0]        p_drive_q, p_drive_d;
  logic [WIDTH-1:0]        n_drive_q, n_drive_d;
  logic [WIDTH-1:0]        delay_q, delay_d;
  logic [WIDTH-1:0]        sense_q, sense_d;
  logic [NTWEAK*WIDTH-1:0] tdrive_q, tdrive_d;

  logic addr_ok;
  logic pwm_edge;
  logic dead_active;

  assign addr_ok     = ({1'b0, field_addr} < DEPTH_A);
  assign pwm_edge    = (pwm != pwm_prev_q);
  assign dead_active = (dead_cnt_q != '0);

  // Field store: writes to unmapped addresses are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) field_q[i] <= '0;
    end else if (field_we && addr_ok) begin
      field_q[field_addr] <= field_wdata;
    end
  end

  // Step counter restarts on a PWM edge and saturates at its top bit.
  always_comb begin
    step_d = step_q;
    if (pwm_edge)                step_d = NSTEPS'(1);
    else if (!step_q[NSTEPS-1])  step_d = step_q << 1;
  end

  // Dead-time down-counter, reloaded by every edge (including one mid-dead-time).
  always_comb begin
    dead_cnt_d = dead_cnt_q;
    if (pwm_edge)          dead_cnt_d = DCW'(DEAD_CYCLES);
    else if (dead_active)  dead_cnt_d = dead_cnt_q - DCW'(1);
  end

  // Read port and driver outputs, computed from the pre-edge phase and counter.
  always_comb begin
    rdata_d   = addr_ok ? field_q[field_addr] : '0;
    delay_d   = pwm_prev_q ? field_q[2] : field_q[PF+2];
    sense_d   = pwm_prev_q ? field_q[1] : field_q[PF+1];
    p_drive_d = '1;
    n_drive_d = '0;
    tdrive_d  = '0;
    if (!dead_active) begin
      if (pwm_prev_q) p_drive_d = field_q[0];
      else            n_drive_d = field_q[PF];
      for (int i = 0; i < NTWEAK; i++) begin
        tdrive_d[i*WIDTH +: WIDTH] = pwm_prev_q ? field_q[3+i] : field_q[PF+3+i];
`ifdef TWEAK_GATE_EN
        if (sense_d[i] != pwm_prev_q) tdrive_d[i*WIDTH +: WIDTH] = '0;
`endif
      end
    end
  end

  // Sequencing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_prev_q <= 1'b0;
      step_q     <= {1'b1, {(NSTEPS-1){1'b0}}};
      dead_cnt_q <= '0;
      rdata_q    <= '0;
      phase_q    <= 1'b0;
      dead_q     <= 1'b0;
      p_drive_q  <= '1;
      n_drive_q  <= '0;
      delay_q    <= '0;
      sense_q    <= '0;
      tdrive_q   <= '0;
    end else begin
      pwm_prev_q <= pwm;
      step_q     <= step_d;
      dead_cnt_q <= dead_cnt_d;
      rdata_q    <= rdata_d;
      phase_q    <= pwm_prev_q;
      dead_q     <= dead_active;
      p_drive_q  <= p_drive_d;
      n_drive_q  <= n_drive_d;
      delay_q    <= delay_d;
      sense_q    <= sense_d;
      tdrive_q   <= tdrive_d;
    end
  end

  assign field_rdata = rdata_q;
  assign step_sel    = step_q;
  assign phase       = phase_q;
  assign dead        = dead_q;
  assign p_drive     = p_drive_q;
  assign n_drive     = n_drive_q;
  assign tweak_delay = delay_q;
  assign tweak_sense = sense_q;
  assign tweak_drive = tdrive_q;

endmodule

// File: tb/tb_drive_phase_sequencer.sv
// Testbench for drive_phase_sequencer: directed scenarios plus random traffic,
// expected outputs from a cycle-indexed reference model pushed to a queue and
// checked by an independent monitor on the falling edge.
module tb_drive_phase_sequencer;
  localparam int W = 8, NT = 8, NS = 8, D = 2, AW = 5;
  localparam int PF = 3 + NT, DEPTH = 2 * PF;

  logic clk = 1'b0;
  logic rst, pwm, we;
  logic [AW-1:0] addr;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata, p_drive, n_drive, t_delay, t_sense;
  logic [NS-1:0] step_sel;
  logic phase, dead;
  logic [NT*W-1:0] t_drive;

  drive_phase_sequencer #(.WIDTH(W), .NTWEAK(NT), .NSTEPS(NS), .DEAD_CYCLES(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pwm(pwm), .field_addr(addr), .field_wdata(wdata), .field_we(we),
    .field_rdata(rdata), .step_sel(step_sel), .phase(phase), .dead(dead),
    .p_drive(p_drive), .n_drive(n_drive), .tweak_delay(t_delay), .tweak_sense(t_sense),
    .tweak_drive(t_drive));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    rdata, p, n, dly, sns;
    logic [NS-1:0]   step;
    logic            phase, dead;
    logic [NT*W-1:0] td;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: timeline of PWM edges and a plain field array.
  logic [W-1:0] fm [DEPTH];
  int  ncyc = 0;
  int  last_edge = 0;
  bit  has_edge = 0;
  bit  m_prev = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response for the edge that just happened, from the inputs applied before it.
  task automatic model_edge();
    exp_t e;
    int base, since;
    logic [W-1:0] lane;
    if (rst) begin
      e.rdata = '0; e.p = '1; e.n = '0; e.dly = '0; e.sns = '0; e.td = '0;
      e.step = 1 << (NS - 1); e.phase = 0; e.dead = 0;
      for (int i = 0; i < DEPTH; i++) fm[i] = '0;
      has_edge = 0; m_prev = 0;
    end else begin
      e.dead  = has_edge && ((ncyc - last_edge) <= D);
      e.phase = m_prev;
      if (pwm != m_prev) begin
        has_edge = 1; last_edge = ncyc;
      end
      since = has_edge ? (ncyc - last_edge) : NS - 1;
      if (since > NS - 1) since = NS - 1;
      e.step  = '0;
      e.step[since] = 1'b1;
      e.rdata = (int'(addr) < DEPTH) ? fm[addr] : '0;
      base    = m_prev ? 0 : PF;
      e.dly   = fm[base + 2];
      e.sns   = fm[base + 1];
      e.p = '1; e.n = '0; e.td = '0;
      if (!e.dead) begin
        if (m_prev) e.p = fm[0];
        else        e.n = fm[PF];
        for (int i = 0; i < NT; i++) begin
          lane = fm[base + 3 + i];
`ifdef TWEAK_GATE_EN
          if (e.sns[i] != m_prev) lane = '0;
`endif
          e.td[i*W +: W] = lane;
        end
      end
      if (we && int'(addr) < DEPTH) fm[addr] = wdata;
      m_prev = pwm;
    end
    exp_q.push_back(e);
    ncyc++;
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      model_edge();
    end
  endtask

  task automatic wr(input int a, input int v);
    we = 1; addr = AW'(a); wdata = W'(v);
    tick();
    we = 0;
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", 64'(rdata), 64'(e.rdata));
        chk("step_sel", 64'(step_sel), 64'(e.step));
        chk("phase", 64'(phase), 64'(e.phase));
        chk("dead", 64'(dead), 64'(e.dead));
        chk("p_drive", 64'(p_drive), 64'(e.p));
        chk("n_drive", 64'(n_drive), 64'(e.n));
        chk("tweak_delay", 64'(t_delay), 64'(e.dly));
        chk("tweak_sense", 64'(t_sense), 64'(e.sns));
        chk("tweak_drive", 64'(t_drive), 64'(e.td));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; pwm = 0; we = 0; addr = '0; wdata = '0;
    tick(2);
    rst = 0;
    tick(10);                              // idle in N, step saturated
    wr(0, 8'h5A); wr(11, 8'hA5);
    pwm = 1; tick(12);                     // single edge with dead-time
    pwm = 0; tick(); pwm = 1; tick(8);     // edge inside dead-time
    wr(22, 8'hFF); addr = 5'd22; tick(2);  // unmapped write and read
    wr(4, 8'h11);
    addr = 5'd4; tick();
    wr(4, 8'h33); addr = 5'd4; tick(2);    // read-during-write returns old value
    wr(1, 8'h01); wr(3, 8'hC3); wr(4, 8'hC3); tick(3);
    pwm = 0; tick(2);                      // into dead-time, then reset
    rst = 1; tick(); rst = 0; tick(4);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 5) == 0) pwm = ~pwm;
      we    = ($urandom_range(0, 2) == 0);
      addr  = AW'($urandom_range(0, 31));
      wdata = W'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; we = 0;
    tick(3);
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
